// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds, flush and error pulses
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     w_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     r_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    // Storage is deliberately not reset; only the pointers define validity.
    logic [DATA_W-1:0] mem [DEPTH];

    // The extra pointer MSB separates a full buffer from an empty one.
    logic [CW-1:0] w_ptr;
    logic [CW-1:0] r_ptr;

    logic wr_acc;
    logic rd_acc;

    // Acceptance uses the registered flags, so a full FIFO can never take a
    // write in the same cycle a read frees a slot (and likewise for empty).
    assign wr_acc = w_en && !full  && !flush;
    assign rd_acc = r_en && !empty && !flush;

    // Occupancy and flags are pure functions of the registered pointers.
    assign count        = w_ptr - r_ptr;
    assign empty        = (w_ptr == r_ptr);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    // Pointer advance; flush rewinds both pointers to the origin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else if (flush) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // Array write at the low address bits of the write pointer.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[w_ptr[AW-1:0]] <= data_in;
        end
    end

    // Registered read data; holds its value when no read is accepted or on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= mem[r_ptr[AW-1:0]];
        end
    end

    // One-cycle status pulses for accepted reads and rejected requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            overflow   <= w_en && full  && !flush;
            underflow  <= r_en && empty && !flush;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - vector-table and corner-sequence bench for sync_fifo_param
module tb_sync_fifo_param;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       w_en;
    logic [7:0] data_in;
    logic       r_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checks;
    int failures;

    sync_fifo_param #(
        .DATA_W(8),
        .DEPTH(8),
        .AFULL_TH(6),
        .AEMPTY_TH(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .w_en(w_en),
        .data_in(data_in),
        .r_en(r_en),
        .data_out(data_out),
        .data_valid(data_valid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic       we;
        logic       re;
        logic [7:0] din;
        logic [3:0] cnt;
        logic       fu;
        logic       em;
        logic       af;
        logic       ae;
        logic [7:0] dout;
        logic       dv;
        logic       ov;
        logic       ud;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic fl, logic we, logic re, logic [7:0] din,
                                logic [3:0] cnt, logic fu, logic em, logic af, logic ae,
                                logic [7:0] dout, logic dv, logic ov, logic ud);
        vec_t v;
        v.fl = fl; v.we = we; v.re = re; v.din = din;
        v.cnt = cnt; v.fu = fu; v.em = em; v.af = af; v.ae = ae;
        v.dout = dout; v.dv = dv; v.ov = ov; v.ud = ud;
        return v;
    endfunction

    // Compare all outputs as one status word: count,full,empty,af,ae,dout,dv,ov,ud.
    task automatic check_all(input string name, input logic [3:0] cnt, input logic fu,
                             input logic em, input logic af, input logic ae,
                             input logic [7:0] dout, input logic dv, input logic ov,
                             input logic ud);
        logic [18:0] act;
        logic [18:0] exp;
        act = {count, full, empty, almost_full, almost_empty, data_out, data_valid, overflow, underflow};
        exp = {cnt, fu, em, af, ae, dout, dv, ov, ud};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got cnt=%0d fu=%b em=%b af=%b ae=%b dout=%h dv=%b ov=%b ud=%b, want cnt=%0d fu=%b em=%b af=%b ae=%b dout=%h dv=%b ov=%b ud=%b",
                     name, count, full, empty, almost_full, almost_empty, data_out, data_valid,
                     overflow, underflow, cnt, fu, em, af, ae, dout, dv, ov, ud);
        end
    endtask

    // Expected flags for DEPTH=8, AFULL_TH=6, AEMPTY_TH=2 derived from the count.
    task automatic check_st(input string name, input logic [3:0] cnt, input logic [7:0] dout,
                            input logic dv, input logic ov, input logic ud);
        check_all(name, cnt, cnt == 4'd8, cnt == 4'd0, cnt >= 4'd6, cnt <= 4'd2, dout, dv, ov, ud);
    endtask

    // Drive one cycle of inputs, then settle on the falling edge for sampling.
    task automatic drive(input logic fl, input logic we, input logic re, input logic [7:0] din);
        flush = fl; w_en = we; r_en = re; data_in = din;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; w_en = 1'b0; r_en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        flush    = 1'b0;
        r_en     = 1'b0;
        data_in  = 8'h99;
        w_en     = 1'b1;
        reset    = 1'b0;

        // Fill, ninth write overflow, full drain, extra read underflow.
        tbl[0]  = mk(0,1,0,8'h10, 4'd1,0,0,0,1, 8'h00,0,0,0);
        tbl[1]  = mk(0,1,0,8'h11, 4'd2,0,0,0,1, 8'h00,0,0,0);
        tbl[2]  = mk(0,1,0,8'h12, 4'd3,0,0,0,0, 8'h00,0,0,0);
        tbl[3]  = mk(0,1,0,8'h13, 4'd4,0,0,0,0, 8'h00,0,0,0);
        tbl[4]  = mk(0,1,0,8'h14, 4'd5,0,0,0,0, 8'h00,0,0,0);
        tbl[5]  = mk(0,1,0,8'h15, 4'd6,0,0,1,0, 8'h00,0,0,0);
        tbl[6]  = mk(0,1,0,8'h16, 4'd7,0,0,1,0, 8'h00,0,0,0);
        tbl[7]  = mk(0,1,0,8'h17, 4'd8,1,0,1,0, 8'h00,0,0,0);
        tbl[8]  = mk(0,1,0,8'hFF, 4'd8,1,0,1,0, 8'h00,0,1,0);
        tbl[9]  = mk(0,0,1,8'h00, 4'd7,0,0,1,0, 8'h10,1,0,0);
        tbl[10] = mk(0,0,1,8'h00, 4'd6,0,0,1,0, 8'h11,1,0,0);
        tbl[11] = mk(0,0,1,8'h00, 4'd5,0,0,0,0, 8'h12,1,0,0);
        tbl[12] = mk(0,0,1,8'h00, 4'd4,0,0,0,0, 8'h13,1,0,0);
        tbl[13] = mk(0,0,1,8'h00, 4'd3,0,0,0,0, 8'h14,1,0,0);
        tbl[14] = mk(0,0,1,8'h00, 4'd2,0,0,0,1, 8'h15,1,0,0);
        tbl[15] = mk(0,0,1,8'h00, 4'd1,0,0,0,1, 8'h16,1,0,0);
        tbl[16] = mk(0,0,1,8'h00, 4'd0,0,1,0,1, 8'h17,1,0,0);
        tbl[17] = mk(0,0,1,8'h00, 4'd0,0,1,0,1, 8'h17,0,0,1);

        // Reset held for three edges with a write pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", 4'd0, 0, 1, 0, 1, 8'h00, 0, 0, 0);
        w_en  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_all("reset_release", 4'd0, 0, 1, 0, 1, 8'h00, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].fl, tbl[i].we, tbl[i].re, tbl[i].din);
            check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].fu, tbl[i].em, tbl[i].af,
                      tbl[i].ae, tbl[i].dout, tbl[i].dv, tbl[i].ov, tbl[i].ud);
        end

        // Twelve more items in two batches of six, crossing the pointer wrap.
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 6; k++) begin
                drive(0, 1, 0, 8'(8'h30 + b * 6 + k));
            end
            for (int k = 0; k < 6; k++) begin
                drive(0, 0, 1, 8'h00);
                check_st($sformatf("wrap_b%0d_r%0d", b, k), 4'(5 - k), 8'(8'h30 + b * 6 + k), 1, 0, 0);
            end
        end

        // Simultaneous read and write while full.
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 8'(8'h40 + k));
        end
        check_st("full_before_rw", 4'd8, 8'h3B, 0, 0, 0);
        drive(0, 1, 1, 8'hEE);
        check_st("full_rw", 4'd7, 8'h40, 1, 1, 0);
        for (int k = 1; k < 8; k++) begin
            drive(0, 0, 1, 8'h00);
            check_st($sformatf("full_rw_drain%0d", k), 4'(7 - k), 8'(8'h40 + k), 1, 0, 0);
        end

        // Simultaneous read and write while empty.
        drive(0, 1, 1, 8'hA5);
        check_st("empty_rw", 4'd1, 8'h47, 0, 0, 1);
        drive(0, 0, 1, 8'h00);
        check_st("empty_rw_read", 4'd0, 8'hA5, 1, 0, 0);

        // Mid-level simultaneous read and write leaves count unchanged.
        drive(0, 1, 0, 8'h11);
        drive(0, 1, 1, 8'h22);
        check_st("mid_rw", 4'd1, 8'h11, 1, 0, 0);
        drive(0, 0, 1, 8'h00);
        check_st("mid_rw_read", 4'd0, 8'h22, 1, 0, 0);

        // Flush with five entries and both requests asserted.
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 8'(8'h50 + k));
        end
        check_st("pre_flush", 4'd5, 8'h22, 0, 0, 0);
        drive(1, 1, 1, 8'hCC);
        check_st("flush", 4'd0, 8'h22, 0, 0, 0);
        drive(0, 1, 1, 8'h66);
        check_st("post_flush_rw", 4'd1, 8'h22, 0, 0, 1);
        drive(0, 0, 1, 8'h00);
        check_st("post_flush_read", 4'd0, 8'h66, 1, 0, 0);

        // Asynchronous reset between clock edges.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 8'(8'h60 + k));
        end
        check_st("pre_areset", 4'd4, 8'h66, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_st("areset_immediate", 4'd0, 8'h00, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive(0, 1, 0, 8'h77);
        check_st("areset_write", 4'd1, 8'h00, 0, 0, 0);
        drive(0, 0, 1, 8'h00);
        check_st("areset_read", 4'd0, 8'h77, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO that generalises the team's 8x8 synchronous FIFO:
- configurable width and depth;
- all DEPTH entries usable, with an occupancy count;
- almost-full and almost-empty thresholds, a synchronous flush, and overflow/underflow error pulses.

It sits between a producer and a consumer in the same clock domain as the standard buffering primitive for the verification benches and datapaths.

## Interface
Parameters:
- DATA_W, 8, data width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH; legal range 0 <= AEMPTY_TH < AFULL_TH <= DEPTH

Ports (CW = $clog2(DEPTH)+1):
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- flush  in  1  synchronous clear of contents
- w_en  in  1  write request
- data_in  in  DATA_W  write data
- r_en  in  1  read request
- data_out  out  DATA_W  registered read data
- data_valid  out  1  one-cycle pulse: data_out updated by an accepted read
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_TH
- almost_empty  out  1  count <= AEMPTY_TH
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected because full
- underflow  out  1  one-cycle pulse: read rejected because empty

## Operation
- Storage: DEPTH x DATA_W array, not reset.
- Pointers: w_ptr and r_ptr, each $clog2(DEPTH)+1 bits.
  - The extra MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2*DEPTH.
  - The address is the low $clog2(DEPTH) bits.
- Write accepted iff w_en && !full && !flush. It stores data_in at the w_ptr address and increments w_ptr.
- Read accepted iff r_en && !empty && !flush. It loads data_out from the r_ptr address, increments r_ptr and pulses data_valid.
- full/empty gate on the registered state at the edge. Therefore:
  - When full, simultaneous w_en+r_en: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.
  - When empty, simultaneous w_en+r_en: write accepted, read rejected, underflow pulses, count becomes 1.
  - Otherwise, simultaneous accepted read and write leave count unchanged.
- count update: +1 on write-only, -1 on read-only, unchanged when both or neither are accepted.
- full, empty, almost_full and almost_empty are combinational from the registered count/pointers. They glitch-free reflect post-edge state.
- overflow = registered (w_en && full && !flush). underflow = registered (r_en && empty && !flush).
- flush (sync, highest priority below reset):
  - w_ptr, r_ptr and count are set to 0; data_valid, overflow and underflow are set to 0.
  - data_out holds its value.
  - w_en/r_en in the same cycle are ignored, with no error pulses.
- data_out holds its last value whenever no read is accepted.
- Reset (reset=0, asynchronous assert, synchronous-safe release): w_ptr=0, r_ptr=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0 ? 1 : 0), effectively 0 for legal params.
  - Asserting reset mid-operation discards all contents immediately, without waiting for clk.

## Timing
- Write-to-read: data written at edge N is readable by r_en sampled at edge N+1, and appears on data_out after edge N+1.
- Read latency: r_en sampled at edge N drives data_out and data_valid=1 after edge N, for one cycle.
- count, full, empty and almost_* update after the same edge that accepts the operation.
- overflow/underflow are valid the cycle after the offending request, one cycle wide per request cycle.
- No combinational path from w_en/r_en/data_in to any output.

## Test plan
- Reset: hold reset=0 for 3 cycles with w_en=1 -> count=0, empty=1, full=0, data_out=0, data_valid=0, no overflow.
- Fill/overflow (DEPTH=8): write 0x10..0x17 -> full=1, count=8, almost_full asserted from count=6. A ninth write of 0xFF -> overflow pulse, count stays 8.
- Drain/underflow and wrap: read 8 times -> data_out 0x10..0x17 in order with data_valid each cycle, almost_empty from count=2, empty=1. An extra read -> underflow pulse, data_out holds 0x17. Then write and read 12 further items -> order preserved across the pointer wrap.
- Simultaneous at boundaries:
  - When full, w_en+r_en -> oldest word read, overflow=1, count=7.
  - When empty, w_en+r_en with 0xA5 -> underflow=1, count=1, next read returns 0xA5.
- Flush: with count=5, assert flush together with w_en and r_en -> count=0, empty=1, no data_valid/overflow/underflow, data_out unchanged.
- Async reset mid-operation: with count=4, drive reset=0 between clock edges -> count=0 and data_out=0 before the next edge. After release, the first write/read pair returns the new data.
